// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//
// Sequencer and two-port round-robin arbiter in front of a shared external
// 64-bit adder. Each requester hands over an operand pair on a valid/ready
// handshake. The winner's operands are registered onto ADD_A/ADD_B. After
// LATENCY settle cycles the adder's SUM/CARRY are captured and returned,
// tagged with the requester ID, on a valid/ready response channel.
//
// Parameters
//   LATENCY      settle cycles between operand issue and result capture (1..15)
//
// Optional feature
//   ADDER_ARB_GNT_CNT_EN  when defined, GNT_CNT0/GNT_CNT1 count accepts per
//                         requester and saturate at 16'hFFFF. When undefined,
//                         both outputs are tied to zero.
//
// Ports
//   CLK, RST_N              clock (rising edge), synchronous active-low reset
//   VALID0/1, A0/B0, A1/B1  request channels from requester 0 / 1
//   READY0/1                request accepted this cycle (combinational)
//   ADD_A, ADD_B            registered operands driven to the adder
//   ADD_SUM, ADD_CARRY      adder result inputs
//   RESP_VALID/RESP_READY   response handshake
//   RESP_SUM, RESP_CARRY    captured adder result
//   RESP_ID                 requester that owns the response
//   BUSY                    an operation is in flight (not IDLE)
//   GNT_CNT0/1              per-requester grant counters
// ---------------------------------------------------------------------------
module adder_arbiter #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        VALID0,
    input  logic        VALID1,
    input  logic [63:0] A0,
    input  logic [63:0] B0,
    input  logic [63:0] A1,
    input  logic [63:0] B1,
    output logic        READY0,
    output logic        READY1,
    output logic [63:0] ADD_A,
    output logic [63:0] ADD_B,
    input  logic [64:0] ADD_SUM,
    input  logic        ADD_CARRY,
    output logic        RESP_VALID,
    input  logic        RESP_READY,
    output logic [64:0] RESP_SUM,
    output logic        RESP_CARRY,
    output logic        RESP_ID,
    output logic        BUSY,
    output logic [15:0] GNT_CNT0,
    output logic [15:0] GNT_CNT1
);

    if (LATENCY == 0 || LATENCY > 15) begin : g_latency_check
        $error("adder_arbiter: LATENCY must be within 1..15");
    end

    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q,      state_d;
    logic        last_q,       last_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [63:0] add_a_q,      add_a_d;
    logic [63:0] add_b_q,      add_b_d;
    logic [64:0] resp_sum_q,   resp_sum_d;
    logic        resp_carry_q, resp_carry_d;
    logic        resp_id_q,    resp_id_d;

    logic        sel;
    logic        accept;

    // Arbitration: on a tie the requester not granted last wins; otherwise
    // whichever one is valid. With no request sel is 0 but no READY rises.
    always_comb begin
        if (VALID0 && VALID1) begin
            sel = ~last_q;
        end else begin
            sel = VALID1;
        end
    end

    assign READY0 = (state_q == ST_IDLE) && VALID0 && !sel;
    assign READY1 = (state_q == ST_IDLE) && VALID1 &&  sel;
    // READYx already implies VALIDx, so either READY is an accept.
    assign accept = READY0 || READY1;

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no
        // path through the case statement can leave one unassigned (latch).
        state_d      = state_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        resp_sum_d   = resp_sum_q;
        resp_carry_d = resp_carry_q;
        resp_id_d    = resp_id_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    add_a_d   = sel ? A1 : A0;
                    add_b_d   = sel ? B1 : B0;
                    resp_id_d = sel;
                    last_d    = sel;
                    cnt_d     = LAT_INIT;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Last settle cycle: the adder output is stable, take it now.
                if (cnt_q == 4'd1) begin
                    resp_sum_d   = ADD_SUM;
                    resp_carry_d = ADD_CARRY;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RESP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the operand and result registers are reset as well as the
    // control state, because they drive outputs that must read zero after
    // reset and an aborted operation's data must not remain visible.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments only, so every flop samples the
        // pre-edge value of the others regardless of statement order.
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            resp_sum_q   <= '0;
            resp_carry_q <= 1'b0;
            resp_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            resp_sum_q   <= resp_sum_d;
            resp_carry_q <= resp_carry_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign ADD_A      = add_a_q;
    assign ADD_B      = add_b_q;
    assign RESP_VALID = (state_q == ST_RESP);
    assign RESP_SUM   = resp_sum_q;
    assign RESP_CARRY = resp_carry_q;
    assign RESP_ID    = resp_id_q;
    assign BUSY       = (state_q != ST_IDLE);

`ifdef ADDER_ARB_GNT_CNT_EN
    logic [15:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [15:0] gnt_cnt1_q, gnt_cnt1_d;

    // Saturating per-requester accept counters; cleared only by reset.
    always_comb begin
        gnt_cnt0_d = gnt_cnt0_q;
        gnt_cnt1_d = gnt_cnt1_q;
        if (READY0 && (gnt_cnt0_q != 16'hFFFF)) begin
            gnt_cnt0_d = gnt_cnt0_q + 16'd1;
        end
        if (READY1 && (gnt_cnt1_q != 16'hFFFF)) begin
            gnt_cnt1_d = gnt_cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            gnt_cnt0_q <= gnt_cnt0_d;
            gnt_cnt1_q <= gnt_cnt1_d;
        end
    end

    assign GNT_CNT0 = gnt_cnt0_q;
    assign GNT_CNT1 = gnt_cnt1_q;
`else
    assign GNT_CNT0 = '0;
    assign GNT_CNT1 = '0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_arbiter
//
// Directed bench for adder_arbiter. Three instances run side by side with
// LATENCY = 1, 3 and 4, each with its own stimulus and a behavioural adder
// on its ADD_* ports. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adder_arbiter;

    localparam int N_DUT = 3;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        valid0     [N_DUT];
    logic        valid1     [N_DUT];
    logic [63:0] a0         [N_DUT];
    logic [63:0] b0         [N_DUT];
    logic [63:0] a1         [N_DUT];
    logic [63:0] b1         [N_DUT];
    logic        ready0     [N_DUT];
    logic        ready1     [N_DUT];
    logic [63:0] add_a      [N_DUT];
    logic [63:0] add_b      [N_DUT];
    logic [64:0] add_sum    [N_DUT];
    logic        add_carry  [N_DUT];
    logic        resp_valid [N_DUT];
    logic        resp_ready [N_DUT];
    logic [64:0] resp_sum   [N_DUT];
    logic        resp_carry [N_DUT];
    logic        resp_id    [N_DUT];
    logic        busy       [N_DUT];
    logic [15:0] gnt0       [N_DUT];
    logic [15:0] gnt1       [N_DUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        adder_arbiter #(.LATENCY(LAT)) u_dut (
            .CLK        (clk),
            .RST_N      (rst_n),
            .VALID0     (valid0[g]),
            .VALID1     (valid1[g]),
            .A0         (a0[g]),
            .B0         (b0[g]),
            .A1         (a1[g]),
            .B1         (b1[g]),
            .READY0     (ready0[g]),
            .READY1     (ready1[g]),
            .ADD_A      (add_a[g]),
            .ADD_B      (add_b[g]),
            .ADD_SUM    (add_sum[g]),
            .ADD_CARRY  (add_carry[g]),
            .RESP_VALID (resp_valid[g]),
            .RESP_READY (resp_ready[g]),
            .RESP_SUM   (resp_sum[g]),
            .RESP_CARRY (resp_carry[g]),
            .RESP_ID    (resp_id[g]),
            .BUSY       (busy[g]),
            .GNT_CNT0   (gnt0[g]),
            .GNT_CNT1   (gnt1[g])
        );

        // Reference external adder.
        assign add_sum[g]   = {1'b0, add_a[g]} + {1'b0, add_b[g]};
        assign add_carry[g] = add_sum[g][64];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion before 500us");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < N_DUT; d++) begin
            valid0[d]     = 1'b0;
            valid1[d]     = 1'b0;
            a0[d]         = '0;
            b0[d]         = '0;
            a1[d]         = '0;
            b1[d]         = '0;
            resp_ready[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Issue one request and consume its response, with bounded waits.
    task automatic do_op(input int d, input logic id, input logic [63:0] a, input logic [63:0] b);
        logic seen;
        seen = 1'b0;
        resp_ready[d] = 1'b1;
        if (id) begin
            valid1[d] = 1'b1;
            a1[d] = a;
            b1[d] = b;
        end else begin
            valid0[d] = 1'b1;
            a0[d] = a;
            b0[d] = b;
        end
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            seen = id ? ready1[d] : ready0[d];
            tick();
        end
        valid0[d] = 1'b0;
        valid1[d] = 1'b0;
        n_tests++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL op_accept_timeout dut%0d: ready=%b, required 1 within 20 cycles", d, seen);
        end
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            seen = resp_valid[d];
            tick();
        end
        n_tests++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL op_resp_timeout dut%0d: resp_valid=%b, required 1 within 40 cycles", d, seen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        for (int d = 0; d < N_DUT; d++) begin
            n_tests++;
            if ({ready0[d], ready1[d], resp_valid[d], resp_carry[d], resp_id[d], busy[d]} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl dut%0d: {rdy0,rdy1,rv,rc,rid,busy}=%b, required 000000", d,
                         {ready0[d], ready1[d], resp_valid[d], resp_carry[d], resp_id[d], busy[d]});
            end
            n_tests++;
            if (add_a[d] !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_add_a dut%0d: got %h, required 0", d, add_a[d]);
            end
            n_tests++;
            if (add_b[d] !== 64'd0) begin
                n_fail++;
                $display("FAIL reset_add_b dut%0d: got %h, required 0", d, add_b[d]);
            end
            n_tests++;
            if (resp_sum[d] !== 65'd0) begin
                n_fail++;
                $display("FAIL reset_resp_sum dut%0d: got %h, required 0", d, resp_sum[d]);
            end
            n_tests++;
            if ({gnt0[d], gnt1[d]} !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_gnt_cnt dut%0d: got %h/%h, required 0/0", d, gnt0[d], gnt1[d]);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    // LATENCY = 1: 5 + 7, response at cycle 2.
    task automatic test_single();
        valid0[0] = 1'b1;
        a0[0] = 64'd5;
        b0[0] = 64'd7;
        resp_ready[0] = 1'b1;
        #1;
        n_tests++;
        if (ready0[0] !== 1'b1 || ready1[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: rdy0/rdy1=%b%b, required 10", ready0[0], ready1[0]);
        end
        tick();
        valid0[0] = 1'b0;
        #1;
        n_tests++;
        if (add_a[0] !== 64'd5 || add_b[0] !== 64'd7) begin
            n_fail++;
            $display("FAIL single_operands: add_a=%0d add_b=%0d, required 5 7", add_a[0], add_b[0]);
        end
        n_tests++;
        if (resp_valid[0] !== 1'b0 || busy[0] !== 1'b1 || ready0[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_wait: rv=%b busy=%b rdy0=%b, required 0 1 0", resp_valid[0], busy[0], ready0[0]);
        end
        tick();
        n_tests++;
        if (resp_valid[0] !== 1'b1 || resp_sum[0] !== 65'd12 || resp_carry[0] !== 1'b0 || resp_id[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp: rv=%b sum=%0d carry=%b id=%b, required 1 12 0 0",
                     resp_valid[0], resp_sum[0], resp_carry[0], resp_id[0]);
        end
        tick();
        n_tests++;
        if (resp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: rv=%b busy=%b, required 0 0", resp_valid[0], busy[0]);
        end
    endtask

    // LATENCY = 1: all-ones + all-ones from requester 1.
    task automatic test_overflow();
        valid1[0] = 1'b1;
        a1[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        b1[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        resp_ready[0] = 1'b1;
        #1;
        n_tests++;
        if (ready1[0] !== 1'b1 || ready0[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_ready: rdy0/rdy1=%b%b, required 01", ready0[0], ready1[0]);
        end
        tick();
        valid1[0] = 1'b0;
        tick();
        n_tests++;
        if (resp_valid[0] !== 1'b1 || resp_sum[0] !== 65'h1_FFFF_FFFF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL overflow_sum: rv=%b sum=%h, required 1 1fffffffffffffffe", resp_valid[0], resp_sum[0]);
        end
        n_tests++;
        if (resp_carry[0] !== 1'b1 || resp_id[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_carry_id: carry=%b id=%b, required 1 1", resp_carry[0], resp_id[0]);
        end
        tick();
    endtask

    // LATENCY = 3: both requesters held valid, four grants 0,1,0,1 every 5 cycles.
    task automatic test_contention();
        int          n_g;
        int          n_r;
        int          g_cyc [4];
        logic        g_id  [4];
        logic        exp_id;
        logic [64:0] exp_sum;
        logic [15:0] exp_cnt;
        n_g = 0;
        n_r = 0;
        do_reset();
        valid0[1] = 1'b1;
        valid1[1] = 1'b1;
        a0[1] = 64'd100;
        b0[1] = 64'd1;
        a1[1] = 64'd200;
        b1[1] = 64'd2;
        resp_ready[1] = 1'b1;
        for (int c = 0; c < 40 && n_g < 4; c++) begin
            #1;
            if (ready0[1] || ready1[1]) begin
                n_tests++;
                if (ready0[1] && ready1[1]) begin
                    n_fail++;
                    $display("FAIL contention_both_ready cycle %0d: rdy0/rdy1=11, required one-hot", c);
                end
                g_cyc[n_g] = c;
                g_id[n_g]  = ready1[1];
                n_g++;
            end
            if (resp_valid[1]) begin
                exp_id  = n_r[0];
                exp_sum = exp_id ? 65'd202 : 65'd101;
                n_tests++;
                if (resp_id[1] !== exp_id || resp_sum[1] !== exp_sum) begin
                    n_fail++;
                    $display("FAIL contention_resp %0d: id=%b sum=%0d, required %b %0d",
                             n_r, resp_id[1], resp_sum[1], exp_id, exp_sum);
                end
                n_r++;
            end
            tick();
        end
        valid0[1] = 1'b0;
        valid1[1] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        n_tests++;
        if (n_g != 4) begin
            n_fail++;
            $display("FAIL contention_grant_count: got %0d, required 4", n_g);
        end
        for (int i = 0; i < n_g; i++) begin
            n_tests++;
            if (g_id[i] !== 1'(i % 2) || g_cyc[i] != i * 5) begin
                n_fail++;
                $display("FAIL contention_grant %0d: id=%b cycle=%0d, required %0d %0d",
                         i, g_id[i], g_cyc[i], i % 2, i * 5);
            end
        end
`ifdef ADDER_ARB_GNT_CNT_EN
        exp_cnt = 16'd2;
`else
        exp_cnt = 16'd0;
`endif
        n_tests++;
        if (gnt0[1] !== exp_cnt || gnt1[1] !== exp_cnt || busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_end: gnt0=%0d gnt1=%0d busy=%b, required %0d %0d 0",
                     gnt0[1], gnt1[1], busy[1], exp_cnt, exp_cnt);
        end
    endtask

    // LATENCY = 3: response held through 5 cycles of RESP_READY low.
    task automatic test_backpressure();
        int c;
        do_reset();
        valid0[1] = 1'b1;
        a0[1] = 64'd10;
        b0[1] = 64'd20;
        #1;
        n_tests++;
        if (ready0[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready: rdy0=%b, required 1", ready0[1]);
        end
        tick();
        // Further requests pending from both sides while busy.
        a1[1] = 64'd40;
        b1[1] = 64'd2;
        valid1[1] = 1'b1;
        c = 1;
        while (!resp_valid[1] && c < 12) begin
            n_tests++;
            if (ready0[1] || ready1[1]) begin
                n_fail++;
                $display("FAIL bp_wait_ready cycle %0d: rdy0/rdy1=%b%b, required 00", c, ready0[1], ready1[1]);
            end
            tick();
            c++;
        end
        n_tests++;
        if (c != 4) begin
            n_fail++;
            $display("FAIL bp_resp_cycle: resp_valid rose at cycle %0d, required 4", c);
        end
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (resp_valid[1] !== 1'b1 || resp_sum[1] !== 65'd30 || resp_id[1] !== 1'b0 ||
                ready0[1] !== 1'b0 || ready1[1] !== 1'b0 || busy[1] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold %0d: rv=%b sum=%0d id=%b rdy=%b%b busy=%b, required 1 30 0 00 1",
                         k, resp_valid[1], resp_sum[1], resp_id[1], ready0[1], ready1[1], busy[1]);
            end
            tick();
        end
        resp_ready[1] = 1'b1;
        tick();
        // Back in IDLE; last grant was 0, so the tie goes to requester 1.
        n_tests++;
        if (busy[1] !== 1'b0 || resp_valid[1] !== 1'b0 || ready0[1] !== 1'b0 || ready1[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: busy=%b rv=%b rdy0/rdy1=%b%b, required 0 0 01",
                     busy[1], resp_valid[1], ready0[1], ready1[1]);
        end
        tick();
        valid0[1] = 1'b0;
        valid1[1] = 1'b0;
        for (int k = 0; k < 6; k++) tick();
    endtask

    // LATENCY = 4: reset during WAIT discards the operation and restores LAST.
    task automatic test_reset_mid_wait();
        do_reset();
        valid0[2] = 1'b1;
        a0[2] = 64'd3;
        b0[2] = 64'd4;
        resp_ready[2] = 1'b1;
        #1;
        n_tests++;
        if (ready0[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL rmw_ready: rdy0=%b, required 1", ready0[2]);
        end
        tick();
        valid0[2] = 1'b0;
        n_tests++;
        if (busy[2] !== 1'b1 || add_a[2] !== 64'd3) begin
            n_fail++;
            $display("FAIL rmw_wait: busy=%b add_a=%0d, required 1 3", busy[2], add_a[2]);
        end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_tests++;
        if ({ready0[2], ready1[2], resp_valid[2], resp_carry[2], resp_id[2], busy[2]} !== 6'b0 ||
            add_a[2] !== 64'd0 || add_b[2] !== 64'd0 || resp_sum[2] !== 65'd0 ||
            gnt0[2] !== 16'd0 || gnt1[2] !== 16'd0) begin
            n_fail++;
            $display("FAIL rmw_reset_values: ctrl=%b add_a=%0d add_b=%0d sum=%0d gnt=%0d/%0d, required all 0",
                     {ready0[2], ready1[2], resp_valid[2], resp_carry[2], resp_id[2], busy[2]},
                     add_a[2], add_b[2], resp_sum[2], gnt0[2], gnt1[2]);
        end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (resp_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL rmw_no_resp %0d: rv=%b busy=%b, required 0 0", k, resp_valid[2], busy[2]);
            end
            tick();
        end
        valid0[2] = 1'b1;
        valid1[2] = 1'b1;
        #1;
        n_tests++;
        if (ready0[2] !== 1'b1 || ready1[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL rmw_tie: rdy0/rdy1=%b%b, required 10", ready0[2], ready1[2]);
        end
        tick();
        valid0[2] = 1'b0;
        valid1[2] = 1'b0;
        for (int k = 0; k < 7; k++) tick();
    endtask

    // Three accepts of requester 0 and two of requester 1.
    task automatic test_gnt_cnt();
        logic [15:0] exp0;
        logic [15:0] exp1;
        do_reset();
        do_op(0, 1'b0, 64'd1, 64'd1);
        do_op(0, 1'b1, 64'd2, 64'd2);
        do_op(0, 1'b0, 64'd3, 64'd3);
        do_op(0, 1'b1, 64'd4, 64'd4);
        do_op(0, 1'b0, 64'd5, 64'd5);
`ifdef ADDER_ARB_GNT_CNT_EN
        exp0 = 16'd3;
        exp1 = 16'd2;
`else
        exp0 = 16'd0;
        exp1 = 16'd0;
`endif
        n_tests++;
        if (gnt0[0] !== exp0 || gnt1[0] !== exp1) begin
            n_fail++;
            $display("FAIL gnt_cnt: gnt0=%0d gnt1=%0d, required %0d %0d", gnt0[0], gnt1[0], exp0, exp1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_overflow();
        test_contention();
        test_backpressure();
        test_reset_mid_wait();
        test_gnt_cnt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
